// File: rtl/vend_controller.sv
// Vending transaction controller: collects coin credit against a fixed price,
// drives the dispenser handshake, then pays change or refunds one ten-unit per ack.
module vend_controller #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_done,
    output logic                change_req,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W:0]  PRICE_V    = (CREDIT_W + 1)'(PRICE);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic                reject_reg;

    logic [CREDIT_W:0]   coin_value;
    logic [CREDIT_W:0]   sum;
    logic                coin_take;
    logic                coin_good;

    always_comb begin
        coin_value = '0;
        case (coin)
            2'b00:   coin_value = (CREDIT_W + 1)'(1);
            2'b01:   coin_value = (CREDIT_W + 1)'(2);
            2'b10:   coin_value = (CREDIT_W + 1)'(5);
            default: coin_value = '0;
        endcase
    end

    // One bit wider than credit so the price comparison never wraps.
    assign sum        = {1'b0, credit_reg} + coin_value;
    assign coin_ready = ((state_reg == IDLE) || (state_reg == COLLECT)) && !cancel && !reset;
    assign coin_take  = coin_valid && coin_ready;
    assign coin_good  = coin_take && (coin != 2'b11);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            credit_reg <= '0;
            timer_reg  <= '0;
            reject_reg <= 1'b0;
        end else begin
            reject_reg <= coin_take && (coin == 2'b11);
            case (state_reg)
                IDLE: begin
                    if (coin_good) begin
                        timer_reg <= '0;
                        if (sum >= PRICE_V) begin
                            credit_reg <= CREDIT_W'(sum - PRICE_V);
                            state_reg  <= VEND;
                        end else begin
                            credit_reg <= CREDIT_W'(sum);
                            state_reg  <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    // Priority: cancel, then a valid coin, then timeout expiry.
                    if (cancel) begin
                        state_reg <= CHANGE;
                        timer_reg <= '0;
                    end else if (coin_good) begin
                        timer_reg <= '0;
                        if (sum >= PRICE_V) begin
                            credit_reg <= CREDIT_W'(sum - PRICE_V);
                            state_reg  <= VEND;
                        end else begin
                            credit_reg <= CREDIT_W'(sum);
                            state_reg  <= COLLECT;
                        end
                    end else if (timer_reg == TIMER_LAST) begin
                        state_reg <= CHANGE;
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                VEND: begin
                    if (vend_done) begin
                        state_reg <= (credit_reg != '0) ? CHANGE : IDLE;
                    end
                end
                CHANGE: begin
                    if (change_ack) begin
                        if (credit_reg <= CREDIT_W'(1)) begin
                            credit_reg <= '0;
                            state_reg  <= IDLE;
                        end else begin
                            credit_reg <= credit_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign credit      = credit_reg;
    assign coin_reject = reject_reg;
    assign vend_req    = (state_reg == VEND);
    assign change_req  = (state_reg == CHANGE);
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: a credit/phase model checked every cycle plus
// hand-computed literal expectations along directed scenarios.
module tb_vend_controller;

    localparam int PRICE   = 4;
    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       coin_ready;
    logic       coin_reject;
    logic       cancel = 1'b0;
    logic       vend_req;
    logic       vend_done = 1'b0;
    logic       change_req;
    logic       change_ack = 1'b0;
    logic [3:0] credit;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: credit in ten-units, whether dispensing, whether paying out, idle cycles.
    int m_credit = 0;
    bit m_vend   = 1'b0;
    bit m_pay    = 1'b0;
    int m_idle   = 0;
    bit m_reject = 1'b0;

    vend_controller #(.PRICE(PRICE), .CREDIT_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .coin_valid (coin_valid),
        .coin       (coin),
        .coin_ready (coin_ready),
        .coin_reject(coin_reject),
        .cancel     (cancel),
        .vend_req   (vend_req),
        .vend_done  (vend_done),
        .change_req (change_req),
        .change_ack (change_ack),
        .credit     (credit),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        automatic int c    = m_credit;
        automatic bit v    = m_vend;
        automatic bit p    = m_pay;
        automatic int idle = m_idle;
        automatic bit rej  = 1'b0;
        automatic bit collecting = !v && !p && (c > 0);
        automatic bit ready      = !v && !p && !cancel;
        automatic int value;
        if (reset) begin
            c = 0; v = 0; p = 0; idle = 0;
        end else if (collecting && cancel) begin
            p = 1; idle = 0;
        end else if (ready && coin_valid && coin != 2'b11) begin
            value = (coin == 2'b00) ? 1 : (coin == 2'b01) ? 2 : 5;
            idle = 0;
            if (c + value >= PRICE) begin
                c = c + value - PRICE; v = 1;
            end else begin
                c = c + value;
            end
        end else if (collecting) begin
            rej = ready && coin_valid;
            idle++;
            if (idle == TIMEOUT) begin
                p = 1; idle = 0;
            end
        end else if (v) begin
            if (vend_done) begin
                v = 0; p = (c > 0);
            end
        end else if (p) begin
            if (change_ack) begin
                c--; p = (c > 0);
            end
        end else begin
            rej = ready && coin_valid;
        end
        m_credit <= c;
        m_vend   <= v;
        m_pay    <= p;
        m_idle   <= idle;
        m_reject <= rej;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            #1;
            check("credit", int'(credit), m_credit);
            check("vend_req", int'(vend_req), int'(m_vend));
            check("change_req", int'(change_req), int'(m_pay));
            check("busy", int'(busy), int'(m_vend || m_pay || m_credit > 0));
            check("coin_reject", int'(coin_reject), int'(m_reject));
            check("coin_ready", int'(coin_ready),
                  int'(!m_vend && !m_pay && !cancel && !reset));
        end
    end

    // Apply inputs for one cycle, then return at the following falling edge.
    task automatic drive(input bit cv, input logic [1:0] cn, input bit cc,
                         input bit vd, input bit ca);
        coin_valid = cv;
        coin       = cn;
        cancel     = cc;
        vend_done  = vd;
        change_ack = ca;
        @(negedge clock);
    endtask

    task automatic idle_cycle();
        drive(0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        @(negedge clock);
        reset = 1'b1;
        idle_cycle();
        chk_en = 1'b1;
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(coin_ready), 0);
        reset = 1'b0;

        // 1: twenty + twenty -> exact price, no change
        drive(1, 2'b01, 0, 0, 0);
        check("s1_credit2", int'(credit), 2);
        drive(1, 2'b01, 0, 0, 0);
        check("s1_vend_req", int'(vend_req), 1);
        check("s1_credit0", int'(credit), 0);
        drive(1, 2'b00, 0, 0, 0);
        check("s1_held_vend", int'(vend_req), 1);
        drive(0, 2'b00, 0, 1, 0);
        check("s1_idle_busy", int'(busy), 0);
        check("s1_no_change", int'(change_req), 0);

        // 2: ten + fifty -> credit 2 change
        drive(1, 2'b00, 0, 0, 0);
        drive(1, 2'b10, 0, 0, 0);
        check("s2_credit2", int'(credit), 2);
        drive(0, 2'b00, 0, 1, 0);
        check("s2_change_req", int'(change_req), 1);
        drive(0, 2'b00, 0, 0, 1);
        check("s2_credit1", int'(credit), 1);
        check("s2_req_held", int'(change_req), 1);
        drive(0, 2'b00, 0, 0, 1);
        check("s2_credit0", int'(credit), 0);
        check("s2_req_drop", int'(change_req), 0);
        check("s2_busy0", int'(busy), 0);

        // 3: invalid coins in IDLE and COLLECT
        drive(1, 2'b11, 0, 0, 0);
        check("s3_rej_idle", int'(coin_reject), 1);
        check("s3_busy_idle", int'(busy), 0);
        idle_cycle();
        check("s3_rej_drop", int'(coin_reject), 0);
        drive(1, 2'b00, 0, 0, 0);
        drive(1, 2'b11, 0, 0, 0);
        check("s3_rej_coll", int'(coin_reject), 1);
        check("s3_credit1", int'(credit), 1);
        idle_cycle();
        check("s3_rej_drop2", int'(coin_reject), 0);
        drive(0, 2'b00, 1, 0, 0);
        drive(0, 2'b00, 0, 0, 1);
        check("s3_refunded", int'(busy), 0);

        // 4: cancel beats a simultaneous coin
        drive(1, 2'b00, 0, 0, 0);
        drive(1, 2'b01, 0, 0, 0);
        check("s4_credit3", int'(credit), 3);
        drive(1, 2'b10, 1, 0, 0);
        check("s4_change", int'(change_req), 1);
        check("s4_credit3b", int'(credit), 3);
        for (int i = 0; i < 3; i++) drive(0, 2'b00, 0, 0, 1);
        check("s4_credit0", int'(credit), 0);
        check("s4_idle", int'(busy), 0);

        // 5: timeout after 16 idle cycles, and a coin on the 16th cycle wins
        drive(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle_cycle();
        check("s5_still_coll", int'(change_req), 0);
        idle_cycle();
        check("s5_timeout", int'(change_req), 1);
        check("s5_credit1", int'(credit), 1);
        drive(0, 2'b00, 0, 0, 1);
        check("s5_idle", int'(busy), 0);
        drive(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle_cycle();
        drive(1, 2'b01, 0, 0, 0);
        check("s5_coin_wins", int'(change_req), 0);
        check("s5_credit3", int'(credit), 3);
        drive(1, 2'b11, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 2; i++) idle_cycle();
        check("s5_rej_no_clr", int'(change_req), 0);
        idle_cycle();
        check("s5_timeout2", int'(change_req), 1);
        for (int i = 0; i < 3; i++) drive(0, 2'b00, 0, 0, 1);
        check("s5_idle2", int'(busy), 0);

        // 6: reset in the middle of a vend
        drive(1, 2'b00, 0, 0, 0);
        drive(1, 2'b10, 0, 0, 0);
        check("s6_vend", int'(vend_req), 1);
        reset = 1'b1;
        idle_cycle();
        check("s6_rst_credit", int'(credit), 0);
        check("s6_rst_vend", int'(vend_req), 0);
        check("s6_rst_busy", int'(busy), 0);
        reset = 1'b0;
        drive(0, 2'b00, 0, 1, 0);
        check("s6_done_ign", int'(busy), 0);
        check("s6_no_change", int'(change_req), 0);
        idle_cycle();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction controller for the coin-operated vending datapath. It accepts encoded coin events from the coin acceptor through a valid/ready handshake and accumulates credit against a fixed price. It sequences the product dispenser through a request/done handshake, then pays out change or refunds one ten-unit coin at a time through a request/acknowledge handshake to the change hopper. It also handles cancel and an inactivity timeout.

## Interface
Parameters:
- PRICE, 4: product price in ten-units (4 = 40). Legal range is 1..15.
- CREDIT_W, 4: credit register width. It must hold PRICE-1+5.
- TIMEOUT, 16: idle cycles allowed in COLLECT before an automatic refund. Must be ≥ 2.

Ports:
- clock, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- coin_valid, input, 1: a coin is presented.
- coin, input, 2: coin code. 00 = ten (1 unit), 01 = twenty (2), 10 = fifty (5), 11 = invalid.
- coin_ready, output, 1: the controller can take a coin this cycle.
- coin_reject, output, 1: one-cycle pulse; an invalid coin was taken and discarded.
- cancel, input, 1: user cancel request.
- vend_req, output, 1: dispense request. Held high until vend_done.
- vend_done, input, 1: dispenser completion.
- change_req, output, 1: request the hopper to pay one ten-unit.
- change_ack, input, 1: one ten-unit has been paid.
- credit, output, CREDIT_W: current credit in ten-units.
- busy, output, 1: high when the state is not IDLE.

## Operation
- **States:** IDLE, COLLECT, VEND, CHANGE. Encoding is 2 bits and registered.
- **Coin acceptance:**
  - coin_ready = (state is IDLE or COLLECT) & !cancel & !reset. It is combinational.
  - A coin is accepted when coin_valid & coin_ready.
  - A coin is never accepted in VEND or CHANGE. The acceptor must hold the coin.
- **Valid coin accepted:**
  - sum = credit + value.
  - If sum ≥ PRICE: credit <= sum − PRICE and the state goes to VEND.
  - Otherwise: credit <= sum and the state goes to COLLECT.
- **Invalid coin (11) accepted:** credit and state are unchanged, coin_reject = 1 for the next cycle, and the timeout counter is not reset.
- **cancel in COLLECT:** the state goes to CHANGE and the full credit is refunded.
- **cancel in IDLE, VEND or CHANGE:** ignored.
- **Timeout counter:**
  - Counts cycles in COLLECT.
  - Cleared on entry to COLLECT and on every accepted valid coin.
  - When it has counted TIMEOUT cycles with no valid coin, the state goes to CHANGE.
- **VEND:**
  - vend_req = 1.
  - On vend_done: if credit > 0 go to CHANGE, else go to IDLE.
  - vend_done outside VEND is ignored.
- **CHANGE:**
  - change_req = 1.
  - Each cycle with change_ack decrements credit by 1.
  - The ack that takes credit to 0 moves the state to IDLE.
  - change_ack outside CHANGE is ignored.
- **Credit bounds:** credit never exceeds PRICE−1 outside VEND/CHANGE. Arithmetic is unsigned, computed one bit wider than CREDIT_W, with no wrap.

## Timing
- **Reset:**
  - State is IDLE.
  - credit, coin_reject, vend_req, change_req, busy and the timer are all 0.
  - coin_ready is 0 while reset is high.
  - Reset asserted in any state, including mid-VEND or mid-CHANGE, takes effect at the next edge. Credit is discarded.
- **Coin to credit/state:**
  - A coin accepted at edge N is reflected in credit, state and busy after edge N.
  - vend_req is high in the cycle after the accepting edge.
- **Output registration:**
  - vend_req, change_req and busy are decoded from the registered state, so they are glitch-free.
  - coin_reject is registered.
- **Dispense handshake:** vend_done sampled high at edge M drops vend_req after edge M.
- **Change handshake:**
  - change_req stays high across consecutive acks.
  - It drops in the cycle after the final ack.
  - Back-to-back acks are legal at one unit per cycle.
- **Simultaneous events:**
  - cancel and coin_valid in the same cycle: cancel wins and the coin is not accepted.
  - Timeout expiry and a valid coin accepted in the same cycle: the coin wins.
- **Next transaction:** from IDLE a new coin can be accepted in the first IDLE cycle.

## Test plan
1. Reset, then twenty and twenty on consecutive cycles. Required: credit = 2 after the first coin; state VEND with credit 0 and vend_req = 1 after the second; vend_done then returns to IDLE with no change_req.
2. ten, then fifty. Required: credit 6 → VEND with credit 2; after vend_done, change_req = 1; two change_ack cycles bring credit 2→1→0; change_req drops and busy = 0.
3. coin = 11 in IDLE, then in COLLECT with credit 1. Required: coin_reject high for exactly one cycle each time; credit stays 0 and then 1.
4. ten and twenty (credit 3), then cancel together with coin_valid (fifty). Required: coin not accepted; state CHANGE; three acks refund the credit to 0; IDLE.
5. ten, then 16 idle cycles. Required: state CHANGE with credit 1; one ack returns to IDLE. A coin on the 16th cycle instead keeps the state in COLLECT.
6. Reset asserted mid-VEND with credit 2, then vend_done pulsed. Required: all outputs 0 and credit 0 after the reset edge; vend_done is ignored; state stays IDLE.
